// File: rtl/gray_seq_gen_pkg.sv
// Shared definitions for the Gray-code stages: FSM encoding, default width
// and a fixed-width binary-to-Gray helper.
package gray_seq_gen_pkg;
  localparam int GRAY_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_seq_gen_bin2gray.sv
// Combinational binary-to-Gray converter, width-parameterised.
module bin2gray import gray_seq_gen_pkg::*; #(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);
  assign g = b ^ (b >> 1);
endmodule

// File: rtl/gray_seq_gen.sv
// Registered Gray-code sequence generator with valid/ready output handshake,
// up/down stepping, load, and wrap or saturate at the ends of the range.
module gray_seq_gen import gray_seq_gen_pkg::*; #(
  parameter int WIDTH    = GRAY_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] g,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             tc,
  output logic             wrap
);
  state_t           state;
  logic [WIDTH-1:0] cnt, cnt_nxt, g_nxt;
  logic             beat, at_end, sat_hit, wrap_nxt;

  assign beat   = g_valid && g_ready;
  assign at_end = up ? (cnt == '1) : (cnt == '0);
  assign tc     = g_valid && at_end;

  // Load overrides the advance but still consumes a coincident beat.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    sat_hit  = 1'b0;
    if (load) begin
      cnt_nxt = load_bin;
    end else if (beat) begin
      wrap_nxt = at_end;
      sat_hit  = SATURATE && at_end;
      if (!sat_hit) cnt_nxt = up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  // g is registered from the next count so it always equals gray(cnt).
  bin2gray #(.WIDTH(WIDTH)) u_b2g (
    .b (cnt_nxt),
    .g (g_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      g       <= '0;
      g_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      g    <= g_nxt;
      wrap <= wrap_nxt;
      case (state)
        ST_IDLE: if (start && !stop) begin
          state   <= ST_RUN;
          g_valid <= 1'b1;
        end
        ST_RUN: if (stop || sat_hit) begin
          state   <= ST_IDLE;
          g_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic model of count, run state and wrap.
module tb_gray_seq_gen;
  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, up = 1'b1, load = 1'b0, g_ready = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] g0, g1;
  logic         v0, v1, tc0, tc1, wr0, wr1;

  int errors = 0, checks = 0;
  int m_cnt[2];
  bit m_run[2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  gray_seq_gen #(.WIDTH(W), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up(up), .load(load),
    .load_bin(load_bin), .g(g0), .g_valid(v0), .g_ready(g_ready), .tc(tc0), .wrap(wr0)
  );

  gray_seq_gen #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up(up), .load(load),
    .load_bin(load_bin), .g(g1), .g_valid(v1), .g_ready(g_ready), .tc(tc1), .wrap(wr1)
  );

  function automatic logic [W-1:0] gray_of(int n);
    logic [W-1:0] r;
    r = W'(n ^ (n >> 1));
    return r;
  endfunction

  function automatic bit m_tc(int k);
    return m_run[k] && (up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_run[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0; stop = 1'b0; load = 1'b0; up = 1'b1; g_ready = 1'b0; load_bin = '0;
  endtask

  // Advance the model on the current inputs, then take one clock edge.
  task automatic step();
    int nc;
    bit nr, nw, beat, term;
    #2;
    for (int k = 0; k < 2; k++) begin
      beat = m_run[k] && g_ready;
      term = up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
      nc = m_cnt[k]; nr = m_run[k]; nw = 1'b0;
      if (load) nc = int'(load_bin);
      else if (beat) begin
        nw = term;
        if (term && k == 1) nr = 1'b0;
        else nc = up ? (m_cnt[k] + 1) % (MAXV + 1) : (m_cnt[k] + MAXV) % (MAXV + 1);
      end
      if (m_run[k] && stop) nr = 1'b0;
      if (!m_run[k] && start && !stop) nr = 1'b1;
      m_cnt[k] = nc; m_run[k] = nr; m_wrap[k] = nw;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    #3 rst_n = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic start_run(input bit dir);
    up = dir; g_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_inputs(); model_reset();
    #1;
    checks++; if (g0 !== '0 || g1 !== '0) begin errors++; $display("FAIL reset_g: g0=%b g1=%b exp 000", g0, g1); end
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: v0=%b v1=%b exp 0", v0, v1); end
    checks++; if ({wr0, wr1, tc0, tc1} !== 4'b0) begin errors++; $display("FAIL reset_wrap_tc: got %b exp 0000", {wr0, wr1, tc0, tc1}); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp_up [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    start_run(1'b1);
    for (int i = 0; i < 9; i++) begin
      checks++; if (g0 !== exp_up[i] || v0 !== 1'b1) begin errors++; $display("FAIL up_seq[%0d]: g=%b v=%b exp %b v=1", i, g0, v0, exp_up[i]); end
      checks++; if (wr0 !== (i == 8)) begin errors++; $display("FAIL up_wrap[%0d]: wrap=%b exp %b", i, wr0, (i == 8)); end
      if (i < 8) begin
        checks++; if (tc0 !== (exp_up[i] == 3'b100)) begin errors++; $display("FAIL up_tc[%0d]: tc=%b exp %b", i, tc0, (exp_up[i] == 3'b100)); end
        step();
      end
    end
  endtask

  task automatic test_count_down();
    logic [W-1:0] exp_dn [9] = '{3'b000, 3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
    logic [W-1:0] prev;
    do_reset();
    start_run(1'b0);
    prev = g0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (g0 !== exp_dn[i]) begin errors++; $display("FAIL dn_seq[%0d]: g=%b exp %b", i, g0, exp_dn[i]); end
      checks++; if (wr0 !== (i == 1)) begin errors++; $display("FAIL dn_wrap[%0d]: wrap=%b exp %b", i, wr0, (i == 1)); end
      if (i > 0) begin
        checks++; if ($countones(g0 ^ prev) != 1) begin errors++; $display("FAIL dn_onebit[%0d]: %b -> %b", i, prev, g0); end
      end
      prev = g0;
      if (i < 8) step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start_run(1'b1);
    step(); step();
    g_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (g0 !== 3'b011 || v0 !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: g=%b v=%b exp 011 v=1", i, g0, v0); end
    end
    g_ready = 1'b1;
    step();
    checks++; if (g0 !== 3'b010) begin errors++; $display("FAIL bp_resume: g=%b exp 010", g0); end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_bin = 3'd5;
    step();
    load = 1'b0;
    checks++; if (g0 !== 3'b111 || v0 !== 1'b0) begin errors++; $display("FAIL load_idle: g=%b v=%b exp 111 v=0", g0, v0); end
    start = 1'b1; g_ready = 1'b0;
    step();
    start = 1'b0;
    checks++; if (g0 !== 3'b111 || v0 !== 1'b1) begin errors++; $display("FAIL load_start: g=%b v=%b exp 111 v=1", g0, v0); end
    load = 1'b1; load_bin = 3'd2; g_ready = 1'b1;
    step();
    load = 1'b0;
    checks++; if (g0 !== 3'b011 || wr0 !== 1'b0) begin errors++; $display("FAIL load_beat: g=%b wrap=%b exp 011 wrap=0", g0, wr0); end
    step();
    checks++; if (g0 !== 3'b010) begin errors++; $display("FAIL load_after: g=%b exp 010", g0); end
  endtask

  task automatic test_saturate();
    do_reset();
    start_run(1'b1);
    for (int i = 0; i < 7; i++) step();
    checks++; if (g1 !== 3'b100 || v1 !== 1'b1 || tc1 !== 1'b1) begin errors++; $display("FAIL sat_term: g=%b v=%b tc=%b exp 100 1 1", g1, v1, tc1); end
    step();
    checks++; if (g1 !== 3'b100 || wr1 !== 1'b1 || v1 !== 1'b0) begin errors++; $display("FAIL sat_hit: g=%b wrap=%b v=%b exp 100 1 0", g1, wr1, v1); end
    step();
    checks++; if (g1 !== 3'b100 || wr1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL sat_after: g=%b wrap=%b v=%b exp 100 0 0", g1, wr1, v1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run(1'b1);
    for (int i = 0; i < 4; i++) step();
    checks++; if (g0 !== 3'b110) begin errors++; $display("FAIL arst_pre: g=%b exp 110", g0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (g0 !== '0 || v0 !== 1'b0 || g1 !== '0 || v1 !== 1'b0) begin errors++; $display("FAIL arst_now: g0=%b v0=%b g1=%b v1=%b exp 0", g0, v0, g1, v1); end
    model_reset();
    #3 rst_n = 1'b1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (v0 !== 1'b0 || v1 !== 1'b0 || g0 !== '0) begin errors++; $display("FAIL start_stop: v0=%b v1=%b g=%b exp 0 0 000", v0, v1, g0); end
  endtask

  task automatic test_random();
    logic [W-1:0] prev;
    bit           prev_beat;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      start    = ($urandom_range(7) == 0);
      stop     = ($urandom_range(15) == 0);
      load     = ($urandom_range(11) == 0);
      load_bin = W'($urandom);
      up       = ($urandom_range(3) != 0);
      g_ready  = ($urandom_range(3) != 0);
      #1;
      checks++; if (tc0 !== m_tc(0) || tc1 !== m_tc(1)) begin errors++; $display("FAIL rnd_tc[%0d]: tc0=%b tc1=%b exp %b %b", n, tc0, tc1, m_tc(0), m_tc(1)); end
      prev = g0;
      prev_beat = v0 && g_ready && !load;
      step();
      checks++; if (g0 !== gray_of(m_cnt[0]) || v0 !== m_run[0] || wr0 !== m_wrap[0]) begin
        errors++; $display("FAIL rnd_wrap_inst[%0d]: g=%b v=%b w=%b exp %b %b %b", n, g0, v0, wr0, gray_of(m_cnt[0]), m_run[0], m_wrap[0]);
      end
      checks++; if (g1 !== gray_of(m_cnt[1]) || v1 !== m_run[1] || wr1 !== m_wrap[1]) begin
        errors++; $display("FAIL rnd_sat_inst[%0d]: g=%b v=%b w=%b exp %b %b %b", n, g1, v1, wr1, gray_of(m_cnt[1]), m_run[1], m_wrap[1]);
      end
      if (prev_beat) begin
        checks++; if ($countones(g0 ^ prev) != 1) begin errors++; $display("FAIL rnd_onebit[%0d]: %b -> %b", n, prev, g0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_backpressure();
    test_load();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
